spi_flash_arbiter: RTL



---
 rtl/spi_flash_pkg.sv | 31 +++
 rtl/spi_flash_arbiter_rr_pick2.sv | 15 +
 rtl/spi_flash_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared widths, state encoding and command payload for the SPI flash arbiter.
package spi_flash_pkg;

    localparam int unsigned FLASH_ADDR_W = 24;
    localparam int unsigned FLASH_DATA_W = 32;
    localparam int unsigned FLASH_QUAD_W = 4;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned ERRC_W       = 8;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic                    write;
        logic [FLASH_QUAD_W-1:0] quad;
        logic [FLASH_ADDR_W-1:0] addr;
        logic [FLASH_DATA_W-1:0] data;
    } flash_cmd_t;

    // Timeout counter saturates instead of wrapping.
    function automatic logic [ERRC_W-1:0] sat_inc(input logic [ERRC_W-1:0] v);
        return (&v) ? v : v + ERRC_W'(1);
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the port not granted last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o_c
);

    always_comb begin
        gnt_o_c = req_i;
        if (req_i == 2'b11) begin
            gnt_o_c = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash controller between the fetch port (0, read-only) and the data port (1),
// holding one latched command until ready or watchdog expiry, then enforcing an idle gap.
module spi_flash_arbiter
    import spi_flash_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    io_req0,
    input  logic [FLASH_ADDR_W-1:0] io_addr0,
    input  logic [FLASH_QUAD_W-1:0] io_quad0,
    output logic                    io_gnt0,
    output logic                    io_rsp_valid0,

    input  logic                    io_req1,
    input  logic                    io_write1,
    input  logic [FLASH_ADDR_W-1:0] io_addr1,
    input  logic [FLASH_DATA_W-1:0] io_wdata1,
    input  logic [FLASH_QUAD_W-1:0] io_quad1,
    output logic                    io_gnt1,
    output logic                    io_rsp_valid1,

    output logic [FLASH_DATA_W-1:0] io_rdata,
    output logic                    io_rsp_err,

    output logic                    io_flash_en,
    output logic                    io_flash_write,
    output logic [FLASH_QUAD_W-1:0] io_quad_io,
    output logic [FLASH_ADDR_W-1:0] io_flash_addr,
    output logic [FLASH_DATA_W-1:0] io_flash_data_in,
    input  logic [FLASH_DATA_W-1:0] io_flash_data_out,
    input  logic                    io_flash_ready,

    output logic                    io_busy,
    output logic [ERRC_W-1:0]       io_err_count
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_GAP  = GAP;

    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic                    last_q, last_d;
    logic                    owner_q, owner_d;
    flash_cmd_t              cmd_q, cmd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic                    rv0_q, rv0_d;
    logic                    rv1_q, rv1_d;
    logic [FLASH_DATA_W-1:0] rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic [ERRC_W-1:0]       errc_q, errc_d;
    logic [1:0]              pick;

    rr_pick2 u_pick (
        .req_i   ({io_req1, io_req0}),
        .last_i  (last_q),
        .gnt_o_c (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= PORT_DATA;
            owner_q <= PORT_IFETCH;
            cmd_q   <= '0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            errc_q  <= errc_d;
        end
    end

    // One down-counter serves as watchdog in BUSY and gap timer in GAP.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        en_d    = en_q;
        errc_d  = errc_q;

        case (state_q)
            S_IDLE: begin
                if (|pick) begin
                    state_d = S_BUSY;
                    en_d    = 1'b1;
                    cnt_d   = TMO_LOAD;
                    if (pick[PORT_DATA]) begin
                        owner_d    = PORT_DATA;
                        last_d     = PORT_DATA;
                        gnt1_d     = 1'b1;
                        cmd_d.write = io_write1;
                        cmd_d.quad  = io_quad1;
                        cmd_d.addr  = io_addr1;
                        cmd_d.data  = io_wdata1;
                    end else begin
                        owner_d    = PORT_IFETCH;
                        last_d     = PORT_IFETCH;
                        gnt0_d     = 1'b1;
                        cmd_d.write = 1'b0;
                        cmd_d.quad  = io_quad0;
                        cmd_d.addr  = io_addr0;
                        cmd_d.data  = '0;
                    end
                end
            end
            S_BUSY: begin
                if (io_flash_ready || (cnt_q == '0)) begin
                    state_d = S_GAP;
                    en_d    = 1'b0;
                    cnt_d   = GAP_LOAD;
                    rv0_d   = (owner_q == PORT_IFETCH);
                    rv1_d   = (owner_q == PORT_DATA);
                    if (io_flash_ready) begin
                        rdata_d = io_flash_data_out;
                        rerr_d  = 1'b0;
                    end else begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        errc_d  = sat_inc(errc_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign io_gnt0          = gnt0_q;
    assign io_gnt1          = gnt1_q;
    assign io_rsp_valid0    = rv0_q;
    assign io_rsp_valid1    = rv1_q;
    assign io_rdata         = rdata_q;
    assign io_rsp_err       = rerr_q;
    assign io_flash_en      = en_q;
    assign io_flash_write   = cmd_q.write;
    assign io_quad_io       = cmd_q.quad;
    assign io_flash_addr    = cmd_q.addr;
    assign io_flash_data_in = cmd_q.data;
    assign io_busy          = busy_q;
    assign io_err_count     = errc_q;

endmodule
